// File: rtl/dport_arbiter.sv
// Round-robin arbiter of NREQ byte requesters onto the debug data port, with halt/drain/done
// end-of-test sequencing. Defining DPORT_CAPTURE_EN adds a capture RAM readable through cap_addr.
module dport_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BYTES = 256,
    parameter int DRAIN_CYC = 4,
    parameter int CNT_W     = 9,
    localparam int AW       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    input  logic                halt,
    output logic [7:0]          dport_out,
    output logic                dport_write,
    output logic                done,
    output logic [CNT_W-1:0]    count,
    output logic                overflow,
    input  logic [AW-1:0]       cap_addr,
    output logic [7:0]          cap_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]       dport_out_q, dport_out_d;
    logic             dport_write_q, dport_write_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       idle_cnt_q, idle_cnt_d;

    logic             sat_s;
    logic             grant_s;
    logic             grant_ok_s;
    logic             idle_s;
    logic [PW-1:0]    win_s;
    logic [7:0]       win_data_s;

    assign sat_s = (count_q == CNT_W'(MAX_BYTES));

    // Round-robin search starting at rr_ptr; the first requesting index wins.
    always_comb begin
        logic [PW-1:0] idx;
        logic          hit;
        idx        = '0;
        hit        = 1'b0;
        grant_s    = 1'b0;
        win_s      = '0;
        win_data_s = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            idx     = PW'((int'(rr_ptr_q) + k) % NREQ);
            hit     = req[idx] & ~grant_s;
            win_s   = hit ? idx : win_s;
            grant_s = grant_s | hit;
        end
        for (int i = 0; i < NREQ; i++) begin
            win_data_s = (PW'(i) == win_s) ? req_data[8*i +: 8] : win_data_s;
        end
    end

    // A grant is only honoured outside DONE, below saturation and never during reset.
    assign grant_ok_s = grant_s && !rst && (state_q != ST_DONE) && !sat_s;
    assign ack        = grant_ok_s ? (NREQ'(1) << win_s) : '0;
    assign idle_s     = (req == '0) || sat_s;

    // Next-state logic for the data path and the RUN/DRAIN/DONE sequencer.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        dport_out_d   = dport_out_q;
        dport_write_d = 1'b0;
        count_d       = count_q;
        overflow_d    = overflow_q;
        idle_cnt_d    = idle_cnt_q;

        if (grant_ok_s) begin
            dport_out_d   = win_data_s;
            dport_write_d = 1'b1;
            count_d       = count_q + CNT_W'(1);
            rr_ptr_d      = PW'((int'(win_s) + 1) % NREQ);
        end else begin
            dport_write_d = 1'b0;
        end

        if (sat_s && (req != '0)) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d    = ST_DRAIN;
                    idle_cnt_d = 4'd0;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Saturated-but-requesting cycles count as idle so DONE is always reachable.
                if (idle_s) begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                    if ((idle_cnt_q + 4'd1) == 4'(DRAIN_CYC)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    idle_cnt_d = 4'd0;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= '0;
            dport_out_q   <= 8'h00;
            dport_write_q <= 1'b0;
            done_q        <= 1'b0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            idle_cnt_q    <= 4'd0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            dport_out_q   <= dport_out_d;
            dport_write_q <= dport_write_d;
            done_q        <= done_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign dport_out   = dport_out_q;
    assign dport_write = dport_write_q;
    assign done        = done_q;
    assign count       = count_q;
    assign overflow    = overflow_q;

`ifdef DPORT_CAPTURE_EN
    logic [7:0] cap_mem [MAX_BYTES];
    logic [7:0] cap_data_q;

    // Capture RAM: written at the pre-increment count on each grant; contents survive rst.
    always_ff @(posedge clk) begin
        if (grant_ok_s) begin
            cap_mem[count_q[AW-1:0]] <= win_data_s;
        end
        cap_data_q <= cap_mem[cap_addr];
    end

    assign cap_data = cap_data_q;
`else
    logic unused_cap_s;
    assign unused_cap_s = ^cap_addr;
    assign cap_data     = 8'h00;
`endif

endmodule

// File: tb/tb_dport_arbiter.sv
// Scoreboard bench for dport_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of round-robin arbitration, saturation and drain sequencing.
`timescale 1ns/1ps
module tb_dport_arbiter;

    localparam int NREQ      = 2;
    localparam int MAX_BYTES = 256;
    localparam int DRAIN_CYC = 4;
    localparam int CNT_W     = 9;
    localparam int AW        = 8;
    localparam int DW        = 8 * NREQ;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [DW-1:0]   req_data;
    logic [NREQ-1:0] ack;
    logic            halt;
    logic [7:0]      dport_out;
    logic            dport_write;
    logic            done;
    logic [CNT_W-1:0] count;
    logic            overflow;
    logic [AW-1:0]   cap_addr;
    logic [7:0]      cap_data;

    always #5 clk = ~clk;

    dport_arbiter #(
        .NREQ(NREQ), .MAX_BYTES(MAX_BYTES), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .halt(halt),
        .dport_out(dport_out), .dport_write(dport_write), .done(done), .count(count),
        .overflow(overflow), .cap_addr(cap_addr), .cap_data(cap_data)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0=RUN 1=DRAIN 2=DONE
    int         m_state = 0;
    int         m_ptr   = 0;
    int         m_count = 0;
    int         m_idle  = 0;
    bit         m_ovf   = 1'b0;
    bit         m_done  = 1'b0;
    logic [7:0] m_last  = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] cap_model [MAX_BYTES];
    bit         cap_valid [MAX_BYTES];
    bit         m_cap_ok  = 1'b0;
    logic [7:0] m_cap_exp = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_winner();
        if (rst || m_state == 2 || m_count >= MAX_BYTES) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (((req >> i) & NREQ'(1)) != '0) return i;
        end
        return -1;
    endfunction

    // One clock: entered just after a negedge with inputs set; returns at the next negedge.
    task automatic step(output int won);
        int              w;
        logic [NREQ-1:0] ea;
        bit              idle;
        #1;
        w  = model_winner();
        ea = (w >= 0) ? (NREQ'(1) << w) : '0;
        check("ack", 32'(ack), 32'(ea));
        @(posedge clk);
        m_cap_ok  = cap_valid[cap_addr];
        m_cap_exp = cap_model[cap_addr];
        if (rst) begin
            m_state = 0; m_ptr = 0; m_count = 0; m_idle = 0;
            m_ovf = 1'b0; m_done = 1'b0;
        end else begin
            idle = (req == '0) || (m_count == MAX_BYTES);
            if (req != '0 && m_count == MAX_BYTES) m_ovf = 1'b1;
            if (w >= 0) begin
                exp_q.push_back(8'(req_data >> (8 * w)));
                cap_model[AW'(m_count)] = 8'(req_data >> (8 * w));
                cap_valid[AW'(m_count)] = 1'b1;
                m_count++;
                m_ptr = (w + 1) % NREQ;
            end
            if (m_state == 0 && halt) begin
                m_state = 1;
                m_idle  = 0;
            end else if (m_state == 1) begin
                m_idle = idle ? m_idle + 1 : 0;
                if (m_idle == DRAIN_CYC) m_state = 2;
            end
            m_done = (m_state == 2);
        end
        won = w;
        @(negedge clk);
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data = (req_data & ~(DW'(8'hFF) << (8 * i))) | (DW'(b) << (8 * i));
    endtask

    task automatic do_reset();
        int w;
        req = '0; halt = 1'b0; rst = 1'b1;
        step(w);
        rst = 1'b0;
    endtask

    // Requesters raise req with fresh data at req_pct%, hold until acked, then drop.
    task automatic rand_phase(input int ncyc, input int req_pct, input int halt_at);
        int w;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((req >> i) & NREQ'(1)) == '0 && $urandom_range(99) < req_pct) begin
                    req = req | (NREQ'(1) << i);
                    set_byte(i, 8'($urandom));
                end
            end
            halt = (c == halt_at);
            step(w);
            if (w >= 0) req = req & ~(NREQ'(1) << w);
        end
        halt = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every cycle and compares the registered outputs.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) m_last = 8'h00;
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("dport_write", 32'(dport_write), 32'(1'b1));
                check("dport_out", 32'(dport_out), 32'(e));
                m_last = e;
            end else begin
                check("dport_write_idle", 32'(dport_write), 32'(1'b0));
                check("dport_out_hold", 32'(dport_out), 32'(m_last));
            end
            check("count", 32'(count), 32'(m_count));
            check("done", 32'(done), 32'(m_done));
            check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef DPORT_CAPTURE_EN
            if (m_cap_ok) check("cap_data", 32'(cap_data), 32'(m_cap_exp));
`else
            check("cap_data", 32'(cap_data), 32'(8'h00));
`endif
        end
    end

    initial begin
        int w;
        rst = 1'b1; req = '0; req_data = '0; halt = 1'b0; cap_addr = '0;
        @(negedge clk);
        step(w); step(w);
        rst = 1'b0;

        // Single stream 41,42,43
        req = 2'b01;
        set_byte(0, 8'h41); step(w);
        set_byte(0, 8'h42); step(w);
        set_byte(0, 8'h43); step(w);
        req = '0; step(w);
        check("single_count", 32'(count), 32'd3);

        // Contention from reset: order 0,1,0,1
        do_reset();
        req = 2'b11; set_byte(0, 8'hA0); set_byte(1, 8'hB0);
        repeat (4) step(w);
        req = '0; step(w);

        // Capture readback of the second byte
        do_reset();
        req = 2'b01;
        set_byte(0, 8'h10); step(w);
        set_byte(0, 8'h20); step(w);
        req = '0; cap_addr = AW'(1);
        step(w); step(w);

        // Drain: 55 granted on the halt cycle, then idle until done
        do_reset();
        req = 2'b01; set_byte(0, 8'h55); halt = 1'b1;
        step(w);
        req = '0; halt = 1'b0;
        repeat (DRAIN_CYC + 2) step(w);
        check("drain_done", 32'(done), 32'd1);
        req = 2'b11; halt = 1'b1;
        repeat (3) step(w);
        req = '0; halt = 1'b0;

        // Randomized traffic with a halt, then quiet to let it drain
        do_reset();
        rand_phase(200, 40, 150);
        rand_phase(12, 0, -1);

        // Saturation: continuous requests past MAX_BYTES, then halt with reqs pending
        do_reset();
        rand_phase(MAX_BYTES + 20, 100, -1);
        rand_phase(DRAIN_CYC + 6, 100, 0);
        check("sat_count", 32'(count), 32'(MAX_BYTES));
        check("sat_overflow", 32'(overflow), 32'd1);
        check("sat_done", 32'(done), 32'd1);

        // Reset mid-op in DRAIN with req pending; rr_ptr must restart at 0
        do_reset();
        halt = 1'b1; step(w);
        halt = 1'b0; req = 2'b01; set_byte(0, 8'h77); step(w);
        req = 2'b10; set_byte(1, 8'h88); rst = 1'b1; step(w);
        rst = 1'b0; req = '0; step(w);
        check("rst_count", 32'(count), 32'd0);
        req = 2'b11; set_byte(0, 8'hC0); set_byte(1, 8'hD0);
        step(w); step(w);
        req = '0; step(w); step(w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
